// File: rtl/tick_sync_pkg.sv
// Shared types and defaults for tick_sync: timer state encoding and parameter defaults.
// The optional watchdog is enabled with the TICK_SYNC_WDOG_EN macro in tick_sync.sv.
package tick_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } timer_state_t;

    localparam int SECONDS_W_DEF   = 6;
    localparam int WDOG_CYCLES_DEF = 67108864;

endpackage

// File: rtl/tick_sync_edge_sync.sv
// edge_sync: multi-flop synchronizer for one divided-clock level plus a registered
// single-cycle strobe on each rising edge of the synchronized level.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_strobe
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] r_fill;
    logic              r_hist;
    logic              r_armed;
    logic              r_strobe;

    // r_fill marks when r_sync's last stage holds a real sample rather than a reset zero,
    // so a level that is already high at reset release cannot arm the edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_fill   <= '0;
            r_hist   <= 1'b0;
            r_armed  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_sync   <= {r_sync[STAGES-2:0], i_level};
            r_fill   <= {r_fill[STAGES-2:0], 1'b1};
            r_hist   <= r_sync[STAGES-1];
            r_armed  <= r_armed | (r_fill[STAGES-1] & ~r_sync[STAGES-1]);
            r_strobe <= r_sync[STAGES-1] & ~r_hist & r_armed;
        end
    end

    assign o_strobe = r_strobe;

endmodule

// File: rtl/tick_sync.sv
// tick_sync: edge strobes for the three divided clocks plus the door/stop seconds timer.
// Define TICK_SYNC_WDOG_EN to add the missing-1s-edge watchdog and its wdog_fault port.
//
// state    | meaning
// ST_IDLE  | timer inactive, remaining = 0
// ST_ALIGN | loaded, waiting for first 1 s tick (not counted)
// ST_RUN   | counting down on each 1 s tick
module tick_sync
    import tick_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SECONDS_W   = SECONDS_W_DEF,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_out_in,
    input  logic                 clk_4hz_in,
    input  logic                 f_1s_in,
    output logic                 tick_fast,
    output logic                 tick_4hz,
    output logic                 tick_1s,
    input  logic                 timer_start,
    input  logic [SECONDS_W-1:0] timer_load,
    input  logic                 timer_abort,
    output logic                 timer_busy,
    output logic                 timer_done,
`ifdef TICK_SYNC_WDOG_EN
    output logic [SECONDS_W-1:0] timer_remaining,
    output logic                 wdog_fault
`else
    output logic [SECONDS_W-1:0] timer_remaining
`endif
);

    logic w_tick_fast;
    logic w_tick_4hz;
    logic w_tick_1s;

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync_fast (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_level  (clk_out_in),
        .o_strobe (w_tick_fast)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync_4hz (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_level  (clk_4hz_in),
        .o_strobe (w_tick_4hz)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_sync_1s (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_level  (f_1s_in),
        .o_strobe (w_tick_1s)
    );

    assign tick_fast = w_tick_fast;
    assign tick_4hz  = w_tick_4hz;
    assign tick_1s   = w_tick_1s;

    timer_state_t         r_state;
    timer_state_t         w_state_nxt;
    logic [SECONDS_W-1:0] r_remaining;
    logic [SECONDS_W-1:0] w_remaining_nxt;
    logic                 r_done;
    logic                 w_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Priority: abort, then start (zero load = immediate done), then the 1 s tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        if (timer_abort) begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = '0;
        end else if (timer_start) begin
            if (timer_load == '0) begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = '0;
                w_done_nxt      = 1'b1;
            end else begin
                w_state_nxt     = ST_ALIGN;
                w_remaining_nxt = timer_load;
            end
        end else if (w_tick_1s) begin
            case (r_state)
                ST_ALIGN: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (r_remaining <= SECONDS_W'(1)) begin
                        w_state_nxt     = ST_IDLE;
                        w_remaining_nxt = '0;
                        w_done_nxt      = 1'b1;
                    end else begin
                        w_remaining_nxt = r_remaining - SECONDS_W'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign timer_busy      = (r_state != ST_IDLE);
    assign timer_done      = r_done;
    assign timer_remaining = r_remaining;

`ifdef TICK_SYNC_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wd_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt   <= '0;
            r_wd_fault <= 1'b0;
        end else if (w_tick_1s) begin
            r_wd_cnt   <= '0;
            r_wd_fault <= 1'b0;
        end else begin
            if (r_wd_cnt != WD_W'(WDOG_CYCLES)) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
            if (r_wd_cnt == WD_W'(WDOG_CYCLES)) begin
                r_wd_fault <= 1'b1;
            end
        end
    end

    assign wdog_fault = r_wd_fault;
`endif

endmodule
